serial_pattern_feeder: RTL
==========================

# serial_pattern_feeder

Upstream stimulus stage for the sequence-detector blocks. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a serial `data` line that connects directly to a detector's `data` input. Back-to-back words stream with no idle gap, so bit patterns that span word boundaries, including overlapping detections, reach the detector intact.

## Interface
- `WIDTH`, default 8: bits per word. Legal range is 2..32.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `load_data`  input  WIDTH  parallel word to serialize.
- `load_valid`  input  1  source has a word on `load_data`.
- `load_ready`  output  1  block accepts a word at this edge if `load_valid` is high.
- `data`  output  1  serial bit stream to the detector.
- `data_valid`  output  1  `data` carries a frame bit this cycle.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  high during the cycle the final frame bit is on `data`.

## Operation
- State machine states:
  - IDLE: no frame in progress.
  - SHIFT: data bits being sent.
  - PARITY: only when `SER_PARITY_EN` is defined.
- Internal registers:
  - `shreg[WIDTH-1:0]`: shift register holding the word.
  - `cnt`: bit counter, sized $clog2(WIDTH).
- Handshake: a transfer occurs at a rising edge where `load_valid && load_ready`. The source must hold `load_data` stable until that edge.
- `load_ready = rst && (state==IDLE || last)`.
  - `last` is high in SHIFT with `cnt==WIDTH-1` when parity is compiled out.
  - `last` is high in the PARITY state when parity is compiled in.
- On a transfer edge:
  - `data` <= `load_data[WIDTH-1]`, `data_valid` <= 1.
  - `shreg` <= `load_data << 1`, `cnt` <= 0, state <= SHIFT.
- In SHIFT, when not `last` or with no new transfer:
  - `data` <= `shreg[WIDTH-1]`, `shreg` <= `shreg << 1`, `cnt` <= `cnt+1`.
  - After bit WIDTH-1, move to PARITY if it is enabled; otherwise return to IDLE.
- IDLE outputs: `data`=0, `data_valid`=0, `busy`=0.
- `busy = (state != IDLE)`.
- `done = last`. It is combinational from registered state and lasts exactly one cycle per frame.
- Back-to-back: a transfer during a `last` cycle starts the next frame immediately. The next cycle carries the new MSB, with no bubble. `done` still pulses for the finishing frame.
- `load_valid` while busy and not `last` has no effect. `load_ready` is 0, so no transfer occurs.
- Reset asserted (`rst`=0) at any time, including mid-frame:
  - state <= IDLE immediately.
  - `data`, `data_valid`, `busy`, `done`, `load_ready` go to 0.
  - `shreg` and `cnt` go to 0.
  - The partial frame is discarded; no `done` is produced.
- Reset value of every output: 0.

## Timing
- Latency: a word accepted at edge N puts its bit k on `data` from edge N+k to edge N+k+1, for k = 0..WIDTH-1.
- Frame length:
  - WIDTH cycles without parity.
  - WIDTH+1 cycles with parity; the parity bit occupies the cycle after edge N+WIDTH.
- `data`, `data_valid`, `shreg`, `cnt` and state are registered. `load_ready`, `busy` and `done` are decoded from registered state only, with no input-to-output combinational path except through `rst`.
- The first transfer is possible at the first rising edge after `rst` deasserts.

## Configuration
- Macro: `SER_PARITY_EN`.
- Defined:
  - After the WIDTH data bits, one extra cycle carries even parity (XOR of the accepted word) with `data_valid`=1.
  - `done` and `load_ready` move to that cycle.
- Undefined:
  - No PARITY state exists.
  - A frame is exactly WIDTH bits, and `done` coincides with the LSB.

## Test plan
- **Reset:** drive `rst`=0 for 2 cycles, then release → all outputs 0 during reset; `load_ready`=1 in the first cycle after release.
- **Single word:** WIDTH=8, `load_data`=8'hA5, one transfer → `data` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; `data_valid`=1 for exactly those 8 cycles; `done`=1 only on the 8th; then IDLE outputs.
- **Back-to-back:** 8'h99 then 8'h33, with `load_valid` held high → 16 contiguous valid bits 10011001_00110011.
  - `load_ready` is high only at the initial IDLE cycle and the two `last` cycles.
  - Two `done` pulses, 8 cycles apart.
  - A downstream 10011 detector asserts `detected` on the expected cycles.
- **Ignored request:** `load_valid`=1 with 8'hFF presented at bit 3 of an 8'hA5 frame → the 8'hA5 frame is unaltered; 8'hFF transfers only at the `last` cycle.
- **Mid-frame reset:** assert `rst`=0 during bit 3 of 8'hA5 → `data`/`data_valid`/`busy` drop to 0 asynchronously; no `done`; the next word after release starts cleanly from its MSB.
- **Parity build:** `SER_PARITY_EN` defined.
  - 8'hA5 → 9 bits, parity bit 0.
  - 8'h07 → parity bit 1.
  - `done` and `load_ready` are high on the 9th cycle.

Source files
------------

// File: rtl/serial_pattern_feeder.sv
// serial_pattern_feeder: parallel word in over valid/ready, MSB-first bit out.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serial_pattern_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             data_n, dv_n;
  logic             last, xfer;

`ifdef SER_PARITY_EN
  logic par, par_n;
  assign last = (state == PARITY);
`else
  assign last = (state == SHIFT) && (cnt == CW'(WIDTH-1));
`endif

  assign load_ready = rst && ((state == IDLE) || last);
  assign xfer       = load_valid && load_ready;
  assign busy       = (state != IDLE);
  assign done       = last;

  // Register state, shifter, counter and the serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
`ifdef SER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      data       <= data_n;
      data_valid <= dv_n;
`ifdef SER_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state: a new word always wins, so frames chain without a bubble.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    data_n  = 1'b0;
    dv_n    = 1'b0;
`ifdef SER_PARITY_EN
    par_n   = par;
`endif
    if (xfer) begin
      state_n = SHIFT;
      data_n  = load_data[WIDTH-1];
      dv_n    = 1'b1;
      shreg_n = load_data << 1;
      cnt_n   = '0;
`ifdef SER_PARITY_EN
      par_n   = ^load_data;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state_n = IDLE;
        end
        SHIFT: begin
          if (cnt == CW'(WIDTH-1)) begin
`ifdef SER_PARITY_EN
            state_n = PARITY;
            data_n  = par;
            dv_n    = 1'b1;
`else
            state_n = IDLE;
`endif
          end else begin
            data_n  = shreg[WIDTH-1];
            dv_n    = 1'b1;
            shreg_n = shreg << 1;
            cnt_n   = cnt + CW'(1);
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          state_n = IDLE;
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule
